mem_initiator: RTL

MEM_INITIATOR -- requirements
Module: mem_initiator

---
 rtl/lsu_pkg.sv | 28 ++
 rtl/lsu_align.sv | 58 +++++
 rtl/mem_initiator.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM state type and alignment helper
// shared by mem_initiator and lsu_align.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    RESP
  } state_t;

  // A half needs an even byte offset, a word (or the 11 encoding) a zero offset.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: is_misaligned = 1'b0;
      SIZE_HALF: is_misaligned = offset[0];
      SIZE_WORD: is_misaligned = (offset != 2'b00);
      default:   is_misaligned = (offset != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane steering for stores and
// lane extraction plus sign/zero extension for loads.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_offset,
  input  logic [31:0] st_wdata,
  output logic [31:0] lane_wdata,
  output logic [3:0]  lane_wmask,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_offset,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Replicate store data across all lanes and strobe only the addressed ones;
  // a misaligned half falls back to the half selected by offset bit 1.
  always_comb begin
    lane_wdata = st_wdata;
    lane_wmask = 4'b1111;
    case (st_size)
      SIZE_BYTE: begin
        lane_wdata = {4{st_wdata[7:0]}};
        lane_wmask = 4'b0001 << st_offset;
      end
      SIZE_HALF: begin
        lane_wdata = {2{st_wdata[15:0]}};
        lane_wmask = 4'b0011 << {st_offset[1], 1'b0};
      end
      SIZE_WORD: begin
        lane_wdata = st_wdata;
        lane_wmask = 4'b1111;
      end
      default: begin
        lane_wdata = st_wdata;
        lane_wmask = 4'b1111;
      end
    endcase
  end

  // Pick the addressed byte/half out of the bus word and extend it to 32 bits.
  always_comb begin
    byte_sel  = ld_rdata[{ld_offset, 3'b000} +: 8];
    half_sel  = ld_rdata[{ld_offset[1], 4'b0000} +: 16];
    load_data = ld_rdata;
    case (ld_size)
      SIZE_BYTE: load_data = ld_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_data = ld_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default:   load_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_initiator.sv
// mem_initiator: single-outstanding load/store bus initiator.
// Optional LSU_MISALIGN_TRAP_EN: misaligned half/word requests are answered
// with an error response and never reach the bus.
module mem_initiator
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_rstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rbusy,
  input  logic        mem_wbusy
);

  state_t      state, state_d;
  logic [31:0] addr_q, wdata_q, rdata_q, wait_cnt;
  logic [3:0]  wmask_q;
  logic [1:0]  size_q, off_q;
  logic        uns_q, err_q;
  logic        trap, timeout_hit, in_wait;
  logic [31:0] lane_wdata, load_data;
  logic [3:0]  lane_wmask;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  assign in_wait     = (state == RD_WAIT) || (state == WR_WAIT);
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_cnt == TIMEOUT_CYCLES - 1);

  lsu_align u_align (
    .st_size     (req_size),
    .st_offset   (req_addr[1:0]),
    .st_wdata    (req_wdata),
    .lane_wdata  (lane_wdata),
    .lane_wmask  (lane_wmask),
    .ld_size     (size_q),
    .ld_offset   (off_q),
    .ld_unsigned (uns_q),
    .ld_rdata    (mem_rdata),
    .load_data   (load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a request is only looked at in IDLE.
  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (trap)        state_d = RESP;
          else if (req_we) state_d = WR_REQ;
          else             state_d = RD_REQ;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      WR_REQ:  state_d = WR_WAIT;
      RD_WAIT: if (!mem_rbusy || timeout_hit) state_d = RESP;
      WR_WAIT: if (!mem_wbusy || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counts cycles spent in the current wait state; cleared whenever it is left.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                          wait_cnt <= '0;
    else if (in_wait && state_d == state) wait_cnt <= wait_cnt + 32'd1;
    else                                wait_cnt <= '0;
  end

  // Request capture on accept, load data capture on responder completion,
  // and error flagging for traps and timeouts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      size_q  <= '0;
      off_q   <= '0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            rdata_q <= '0;
            err_q   <= trap;
            if (!trap) begin
              addr_q  <= {req_addr[31:2], 2'b00};
              wdata_q <= lane_wdata;
              wmask_q <= lane_wmask;
              size_q  <= req_size;
              off_q   <= req_addr[1:0];
              uns_q   <= req_unsigned;
            end
          end
        end
        RD_WAIT: begin
          if (!mem_rbusy)       rdata_q <= load_data;
          else if (timeout_hit) err_q   <= 1'b1;
        end
        WR_WAIT: begin
          if (mem_wbusy && timeout_hit) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign mem_rstrb  = (state == RD_REQ);
  assign mem_wmask  = (state == WR_REQ) ? wmask_q : 4'b0000;
  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = rdata_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule
